ep0_in_data_tx: RTL and testbench

//  Transmit side of the EP0 control pipe. Sources the device-to-host DATA stage
//  of a control-read transfer. Reads bytes from a descriptor ROM, splits them into
//  MAX_PKT-sized packets and hands each packet to the packet serializer. Keeps the

---
 rtl/ep0_in_data_tx.sv | 166 ++++++++++++++++
 tb/tb_ep0_in_data_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ep0_in_data_tx.sv
// EP0 IN data-stage transmitter: streams a descriptor from ROM to the USB TX
// serializer in MAX_PKT-sized packets, tracking DATA0/DATA1 and retrying
// packets that the host does not acknowledge.
module ep0_in_data_tx #(
    parameter int MAX_PKT = 64,
    parameter int ADDR_W  = 8
) (
    input  logic              clk48,
    input  logic              reset,
    input  logic              bus_reset,
    input  logic              abort,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       desc_len,
    input  logic [15:0]       req_len,
    input  logic              in_token,
    input  logic              out_token,
    input  logic              hs_ack,
    input  logic              hs_timeout,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tx_start,
    output logic [6:0]        tx_len,
    output logic              tx_data1,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [15:0] MAX16 = 16'(MAX_PKT);

    typedef enum logic [2:0] {
        IDLE, WAIT_TOKEN, HDR, FETCH, SEND, WAIT_HS, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       rem;
    logic [ADDR_W-1:0] addr, pkt_addr, cur_addr;
    logic              toggle, zlp_need;
    logic [6:0]        pkt_len, byte_cnt;
    logic [7:0]        data_q;
    logic              first;

    // Any of these drops the transfer on the spot.
    logic kill;
    assign kill = reset | bus_reset | abort;

    logic [15:0] start_rem, rem_after;
    logic [6:0]  next_pkt;
    logic        last_byte;
    assign start_rem = (desc_len < req_len) ? desc_len : req_len;
    assign next_pkt  = (rem < MAX16) ? rem[6:0] : MAX16[6:0];
    assign rem_after = rem - {9'd0, pkt_len};
    assign last_byte = ((byte_cnt + 7'd1) == pkt_len);

    // State register.
    always_ff @(posedge clk48) begin
        if (kill) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        rom_rd    = 1'b0;
        rom_addr  = '0;
        tx_start  = 1'b0;
        tx_len    = 7'd0;
        tx_data1  = 1'b0;
        tx_data   = 8'd0;
        tx_valid  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start) state_nxt = WAIT_TOKEN;
            WAIT_TOKEN: begin
                if (in_token)       state_nxt = HDR;
                else if (out_token) state_nxt = DONE;
            end
            HDR: begin
                tx_start  = 1'b1;
                tx_len    = pkt_len;
                tx_data1  = toggle;
                state_nxt = (pkt_len == 7'd0) ? WAIT_HS : FETCH;
            end
            FETCH: begin
                rom_rd    = 1'b1;
                rom_addr  = cur_addr;
                state_nxt = SEND;
            end
            SEND: begin
                // ROM answers in the first SEND cycle; later stall cycles
                // replay the captured copy so the byte stays stable.
                tx_valid = 1'b1;
                tx_data  = first ? rom_data : data_q;
                if (tx_ready) state_nxt = last_byte ? WAIT_HS : FETCH;
            end
            WAIT_HS: begin
                if (hs_ack)
                    state_nxt = (rem_after != 16'd0 || zlp_need) ? WAIT_TOKEN : DONE;
                else if (hs_timeout)
                    state_nxt = WAIT_TOKEN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer bookkeeping: remaining length, addresses, toggle, byte counter.
    always_ff @(posedge clk48) begin
        if (kill) begin
            rem      <= 16'd0;
            addr     <= '0;
            pkt_addr <= '0;
            cur_addr <= '0;
            toggle   <= 1'b0;
            zlp_need <= 1'b0;
            pkt_len  <= 7'd0;
            byte_cnt <= 7'd0;
            data_q   <= 8'd0;
            first    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rem      <= start_rem;
                    addr     <= base_addr;
                    toggle   <= 1'b1;
                    zlp_need <= (desc_len < req_len) && ((start_rem % MAX16) == 16'd0);
                end
                WAIT_TOKEN: if (in_token) begin
                    pkt_len  <= next_pkt;
                    pkt_addr <= addr;
                    cur_addr <= addr;
                end
                HDR:   byte_cnt <= 7'd0;
                FETCH: first    <= 1'b1;
                SEND: begin
                    first <= 1'b0;
                    if (first) data_q <= rom_data;
                    if (tx_ready) begin
                        cur_addr <= cur_addr + 1'b1;
                        byte_cnt <= byte_cnt + 7'd1;
                    end
                end
                WAIT_HS: begin
                    if (hs_ack) begin
                        rem    <= rem_after;
                        addr   <= addr + ADDR_W'(pkt_len);
                        toggle <= ~toggle;
                        if (rem_after == 16'd0) zlp_need <= 1'b0;
                    end else if (hs_timeout) begin
                        cur_addr <= pkt_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ep0_in_data_tx.sv
// Bench for ep0_in_data_tx: directed table of control-read transfers,
// hand-written abort/stall/status-skip sequences, then random transfers
// checked against a packet-list model of the DATA stage.
module tb_ep0_in_data_tx;

    logic       clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    logic       reset, bus_reset, abort, start;
    logic [7:0] base_addr;
    logic [15:0] desc_len, req_len;
    logic       in_token, out_token, hs_ack, hs_timeout;
    logic       rom_rd;
    logic [7:0] rom_addr, rom_data;
    logic       tx_start, tx_data1, tx_valid, tx_ready, busy, done;
    logic [6:0] tx_len;
    logic [7:0] tx_data;

    ep0_in_data_tx #(.MAX_PKT(64), .ADDR_W(8)) dut (
        .clk48(clk48), .reset(reset), .bus_reset(bus_reset), .abort(abort),
        .start(start), .base_addr(base_addr), .desc_len(desc_len), .req_len(req_len),
        .in_token(in_token), .out_token(out_token), .hs_ack(hs_ack), .hs_timeout(hs_timeout),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_start(tx_start), .tx_len(tx_len), .tx_data1(tx_data1), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    // Synchronous descriptor ROM: data one cycle after the read strobe.
    logic [7:0] rom [256];
    always @(posedge clk48) if (rom_rd) rom_data <= rom[rom_addr];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input int base, input int dlen, input int rlen);
        @(negedge clk48);
        base_addr = 8'(base);
        desc_len  = 16'(dlen);
        req_len   = 16'(rlen);
        start     = 1'b1;
        @(negedge clk48);
        start     = 1'b0;
    endtask

    // Runs one full control-read DATA stage acting as host and serializer.
    // tmask bit n forces a timeout on the n-th transmission attempt.
    task automatic run_xfer(input int base, input int dlen, input int rlen,
                            input int tmask, input int rdy_pct,
                            output int npkt, output int flen, output int llen, output int ld1);
        int el[$], eo[$];
        int rem, off, l, attempt, got, nb, cyc, obs_len, obs_d1, prev_hold, prev_data;
        bit zlp, to, last, r;
        // Expected packet list: full packets, a short tail, and a trailing
        // ZLP only when the host asked for more than a packet-multiple.
        rem = (dlen < rlen) ? dlen : rlen;
        zlp = (dlen < rlen) && (rem % 64 == 0);
        off = 0;
        forever begin
            l = (rem < 64) ? rem : 64;
            el.push_back(l); eo.push_back(off);
            rem -= l; off += l;
            if (rem == 0) begin
                if (zlp) zlp = 0;
                else break;
            end
        end
        npkt = 0; flen = -1; llen = -1; ld1 = -1; attempt = 0;
        pulse_start(base, dlen, rlen);
        for (int i = 0; i < el.size(); ) begin
            in_token = 1'b1;
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                @(negedge clk48);
                in_token = 1'b0;
                if (tx_start) got = 1;
            end
            chk("tx_start_seen", got, 1);
            if (got == 0) begin
                abort = 1'b1; @(negedge clk48); abort = 1'b0;
                return;
            end
            obs_len = int'(tx_len); obs_d1 = int'(tx_data1);
            chk("tx_len", obs_len, el[i]);
            chk("tx_data1", obs_d1, (i % 2 == 0) ? 1 : 0);
            nb = 0; cyc = 0; prev_hold = 0; prev_data = 0;
            while (nb < el[i] && cyc < 2000) begin
                @(negedge clk48);
                cyc++;
                if (prev_hold != 0) begin
                    chk("hold_valid", int'(tx_valid), 1);
                    chk("hold_data", int'(tx_data), prev_data);
                end
                if (tx_valid) begin
                    r = ($urandom_range(99) < rdy_pct);
                    if (r) begin
                        chk("byte", int'(tx_data), int'(rom[(base + eo[i] + nb) & 255]));
                        nb++;
                    end
                    prev_hold = r ? 0 : 1;
                    prev_data = int'(tx_data);
                    tx_ready = r;
                end else begin
                    prev_hold = 0;
                    tx_ready = 1'b0;
                end
            end
            chk("bytes_sent", nb, el[i]);
            @(negedge clk48);
            tx_ready = 1'b0;
            to = (attempt < 31) ? tmask[attempt] : 1'b0;
            attempt++;
            if (to) hs_timeout = 1'b1;
            else    hs_ack     = 1'b1;
            @(negedge clk48);
            hs_ack = 1'b0; hs_timeout = 1'b0;
            last = !to && (i == el.size() - 1);
            chk("done_pulse", int'(done), last ? 1 : 0);
            chk("busy_in_xfer", int'(busy), 1);
            if (!to) begin
                npkt++;
                if (npkt == 1) flen = obs_len;
                llen = obs_len; ld1 = obs_d1;
                i++;
            end
        end
        @(negedge clk48);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
    endtask

    typedef struct {
        int base, dlen, rlen, tmask, npkt, flen, llen, ld1;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int np, fl, ll, d1, base, dlen, rlen, got, d;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 37 + 11) ^ 8'h5a;

        reset = 1'b1; bus_reset = 1'b0; abort = 1'b0; start = 1'b0;
        base_addr = 8'd0; desc_len = 16'd0; req_len = 16'd0;
        in_token = 1'b0; out_token = 1'b0; hs_ack = 1'b0; hs_timeout = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk48);
        reset = 1'b0;
        @(negedge clk48);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_rom_rd", int'(rom_rd), 0);
        chk("rst_tx_len", int'(tx_len), 0);
        chk("rst_tx_data", int'(tx_data), 0);

        //            base dlen rlen tmask npkt flen llen ld1
        tbl[0] = '{  10,  18,  64, 0, 1, 18, 18, 1};
        tbl[1] = '{ 200, 128, 255, 0, 3, 64,  0, 1};
        tbl[2] = '{   0, 100,  40, 0, 1, 40, 40, 1};
        tbl[3] = '{   5,   0,   0, 0, 1,  0,  0, 1};
        tbl[4] = '{   7,  64, 100, 0, 2, 64,  0, 0};
        tbl[5] = '{   7,  64,  64, 0, 1, 64, 64, 1};
        tbl[6] = '{  90, 130, 130, 0, 3, 64,  2, 1};
        tbl[7] = '{  50, 100, 200, 1, 2, 64, 36, 0};
        foreach (tbl[k]) begin
            run_xfer(tbl[k].base, tbl[k].dlen, tbl[k].rlen, tbl[k].tmask, 100, np, fl, ll, d1);
            chk($sformatf("tbl%0d_npkt", k), np, tbl[k].npkt);
            chk($sformatf("tbl%0d_first_len", k), fl, tbl[k].flen);
            chk($sformatf("tbl%0d_last_len", k), ll, tbl[k].llen);
            chk($sformatf("tbl%0d_last_d1", k), d1, tbl[k].ld1);
        end

        // Abort while a byte is presented: drops out with no done pulse.
        pulse_start(10, 18, 64);
        in_token = 1'b1; got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk48); in_token = 1'b0;
            if (tx_valid) got = 1;
        end
        chk("abort_reach_send", got, 1);
        abort = 1'b1;
        @(negedge clk48);
        abort = 1'b0;
        chk("abort_tx_valid", int'(tx_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk48);
        chk("abort_no_late_done", int'(done), 0);
        run_xfer(20, 18, 64, 0, 100, np, fl, ll, d1);
        chk("post_abort_npkt", np, 1);
        chk("post_abort_d1", d1, 1);

        // Serializer stall: byte and valid held, ROM not re-read.
        pulse_start(33, 18, 64);
        in_token = 1'b1; got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk48); in_token = 1'b0;
            if (tx_valid) got = 1;
        end
        chk("stall_reach_send", got, 1);
        d = int'(tx_data);
        chk("stall_first_byte", d, int'(rom[33]));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk48);
            chk("stall_valid", int'(tx_valid), 1);
            chk("stall_data", int'(tx_data), d);
            chk("stall_rom_rd", int'(rom_rd), 0);
        end
        bus_reset = 1'b1;
        @(negedge clk48);
        bus_reset = 1'b0;
        chk("busrst_busy", int'(busy), 0);
        chk("busrst_tx_valid", int'(tx_valid), 0);

        // Host skips straight to the status stage.
        pulse_start(0, 18, 64);
        out_token = 1'b1;
        @(negedge clk48);
        out_token = 1'b0;
        chk("skip_done", int'(done), 1);
        chk("skip_tx_start", int'(tx_start), 0);
        @(negedge clk48);
        chk("skip_idle", int'(busy), 0);

        // Random transfers against the packet-list model.
        for (int n = 0; n < 25; n++) begin
            base = int'($urandom_range(255));
            dlen = int'($urandom_range(1, 200));
            if ($urandom_range(3) == 0) dlen = 64 * int'($urandom_range(1, 3));
            rlen = ($urandom_range(1) == 0) ? int'($urandom_range(0, 255)) : dlen + int'($urandom_range(0, 2));
            run_xfer(base, dlen, rlen, int'($urandom & $urandom & 32'h3fff),
                     int'($urandom_range(30, 100)), np, fl, ll, d1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
